// File: rtl/display_pkg.sv
// Shared display constants: active-low segment patterns, the BCD
// converter state type and the per-count BCD record.
package display_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // One converted count: ovf marks 100..127, which is shown as dashes.
  typedef struct packed {
    logic       ovf;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_val_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to BCD converter (shift-add-3, one bit per
// cycle). A start seen in IDLE loads the operand; after 7 SHIFT cycles
// the result is presented for exactly one DONE cycle.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf,
  output logic       done
);

  localparam logic [2:0] LAST_SHIFT = 3'd6;

  bcd_state_t  state;
  bcd_state_t  state_nxt;
  logic [2:0]  shift_cnt;
  logic [6:0]  bin_sh;
  logic [11:0] bcd;

  // Correct every BCD nibble that would overflow on doubling, then shift
  // the next binary bit in. Hundreds never exceeds 1, so it needs no fix.
  function automatic logic [11:0] shift_add3(input logic [11:0] b,
                                             input logic        bit_in);
    logic [11:0] a;
    a = b;
    if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
    return {a[10:0], bit_in};
  endfunction

  // State register and SHIFT-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == SHIFT) shift_cnt <= shift_cnt + 3'd1;
      else                shift_cnt <= '0;
    end
  end

  // Next state; a start outside IDLE is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == LAST_SHIFT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand load and shift-add-3 datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh <= '0;
      bcd    <= '0;
    end else if (state == IDLE && start) begin
      bin_sh <= bin;
      bcd    <= '0;
    end else if (state == SHIFT) begin
      bcd    <= shift_add3(bcd, bin_sh[6]);
      bin_sh <= {bin_sh[5:0], 1'b0};
    end
  end

  assign done = (state == DONE);
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];
  assign ovf  = (bcd[11:8] != 4'd0);

endmodule

// File: rtl/sevenseg_cnt_driver.sv
// Four-digit multiplexed seven-segment driver showing two card counts:
// deck count on DIGIT[3:2], opponent count on DIGIT[1:0]. Counts are
// sampled once per frame, converted to BCD, and swapped into the
// displayed registers only at the frame wrap so a frame never tears.
module sevenseg_cnt_driver
  import display_pkg::*;
#(
  parameter int SCAN_TICKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] deck_card_cnt,
  input  logic [6:0] oppo_card_cnt,
  output logic [6:0] DISPLAY,
  output logic [3:0] DIGIT
);

  localparam int            PW        = $clog2(SCAN_TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_TICKS - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          tick;
  logic          capture;
  logic          wrap;

  logic [3:0] deck_tens, deck_ones, oppo_tens, oppo_ones;
  logic       deck_ovf, oppo_ovf, deck_done, oppo_done;

  bcd_val_t pend_deck, pend_oppo;
  bcd_val_t disp_deck, disp_oppo;
  bcd_val_t disp_deck_nxt, disp_oppo_nxt;
  logic [6:0] seg_nxt;

  // Pattern for one digit position of a converted count.
  function automatic logic [6:0] seg_of(input bcd_val_t v, input logic tens_pos);
    logic [3:0] d;
    if (v.ovf) return SEG_DASH;
    d = tens_pos ? v.tens : v.ones;
    if (tens_pos && d == 4'd0) return SEG_BLANK;
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  assign tick    = (presc == PRESC_MAX);
  assign capture = tick && (idx == 2'd2);
  assign wrap    = tick && (idx == 2'd3);
  assign idx_nxt = tick ? idx + 2'd1 : idx;

  // Prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      idx   <= idx_nxt;
    end
  end

  bin2bcd_seq u_deck_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (capture),
    .bin   (deck_card_cnt),
    .tens  (deck_tens),
    .ones  (deck_ones),
    .ovf   (deck_ovf),
    .done  (deck_done)
  );

  bin2bcd_seq u_oppo_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (capture),
    .bin   (oppo_card_cnt),
    .tens  (oppo_tens),
    .ones  (oppo_ones),
    .ovf   (oppo_ovf),
    .done  (oppo_done)
  );

  // Pending results, written when each converter finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_deck <= '0;
      pend_oppo <= '0;
    end else begin
      if (deck_done) pend_deck <= '{ovf: deck_ovf, tens: deck_tens, ones: deck_ones};
      if (oppo_done) pend_oppo <= '{ovf: oppo_ovf, tens: oppo_tens, ones: oppo_ones};
    end
  end

  assign disp_deck_nxt = wrap ? pend_deck : disp_deck;
  assign disp_oppo_nxt = wrap ? pend_oppo : disp_oppo;

  // Displayed values, swapped only at the frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_deck <= '0;
      disp_oppo <= '0;
    end else begin
      disp_deck <= disp_deck_nxt;
      disp_oppo <= disp_oppo_nxt;
    end
  end

  // Segment pattern for the digit that will be lit after this edge
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (idx_nxt)
      2'd0: seg_nxt = seg_of(disp_oppo_nxt, 1'b0);
      2'd1: seg_nxt = seg_of(disp_oppo_nxt, 1'b1);
      2'd2: seg_nxt = seg_of(disp_deck_nxt, 1'b0);
      2'd3: seg_nxt = seg_of(disp_deck_nxt, 1'b1);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  // Registered outputs; anode and segments always change together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DIGIT   <= 4'b1111;
      DISPLAY <= SEG_BLANK;
    end else begin
      DIGIT   <= ~(4'b0001 << idx_nxt);
      DISPLAY <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_cnt_driver.sv
// Bench for sevenseg_cnt_driver with SCAN_TICKS=16: a reference model
// pushes the four expected digits of a frame when counts are driven,
// and each displayed digit is popped and compared as it lights up.
module tb_sevenseg_cnt_driver;
  import display_pkg::*;

  localparam int SCAN = 16;
  localparam int WAIT_LIMIT = 400;
  localparam logic [3:0] PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] deck_card_cnt = 7'd0;
  logic [6:0] oppo_card_cnt = 7'd0;
  logic [6:0] DISPLAY;
  logic [3:0] DIGIT;

  int   n_cmp = 0;
  int   n_err = 0;
  int   onehot_bad = 0;
  logic run_q;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];

  sevenseg_cnt_driver #(.SCAN_TICKS(SCAN)) dut (
    .clk           (clk),
    .rst           (rst),
    .deck_card_cnt (deck_card_cnt),
    .oppo_card_cnt (oppo_card_cnt),
    .DISPLAY       (DISPLAY),
    .DIGIT         (DIGIT)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  always @(negedge clk) begin
    if (run_q && !rst && $countones(DIGIT) != 3) onehot_bad <= onehot_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic logic [6:0] ref_tens(input int v);
    if (v >= 100) return 7'h3F;
    if (v < 10) return 7'h7F;
    return ref_digit(v / 10);
  endfunction

  function automatic logic [6:0] ref_ones(input int v);
    if (v >= 100) return 7'h3F;
    return ref_digit(v % 10);
  endfunction

  task automatic push_exp(input int deck, input int oppo);
    sb.push_back('{dig: 4'b1110, seg: ref_ones(oppo)});
    sb.push_back('{dig: 4'b1101, seg: ref_tens(oppo)});
    sb.push_back('{dig: 4'b1011, seg: ref_ones(deck)});
    sb.push_back('{dig: 4'b0111, seg: ref_tens(deck)});
  endtask

  // Wait (at negedges) for DIGIT to change into pat; n = negedges waited.
  task automatic wait_to(input logic [3:0] pat, output int n);
    bit seen_other;
    bit hit;
    n = 0;
    hit = 0;
    seen_other = (DIGIT !== pat);
    while (!hit && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
      if (DIGIT !== pat) seen_other = 1;
      else if (seen_other) hit = 1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_digit: DIGIT=%b never became %b", DIGIT, pat);
    end
  endtask

  // Pop one frame from the scoreboard while the DUT scans it; called at
  // the first negedge of digit 0.
  task automatic drain_frame(input int first_len, input string tag);
    exp_t e;
    int   n;
    int   want;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        wait_to(PAT[k], n);
        want = (k == 1) ? first_len : SCAN;
        n_cmp++;
        if (n !== want) begin
          n_err++;
          $display("FAIL %s period_d%0d: got %0d cycles, want %0d", tag, k, n, want);
        end
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s scoreboard_empty at d%0d", tag, k);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (DIGIT !== e.dig || DISPLAY !== e.seg) begin
          n_err++;
          $display("FAIL %s d%0d: DIGIT=%b DISPLAY=%b, want DIGIT=%b DISPLAY=%b",
                   tag, k, DIGIT, DISPLAY, e.dig, e.seg);
        end
      end
    end
  endtask

  task automatic show_and_check(input int deck, input int oppo, input string tag);
    int n;
    wait_to(4'b1110, n);
    deck_card_cnt = 7'(deck);
    oppo_card_cnt = 7'(oppo);
    push_exp(deck, oppo);
    wait_to(4'b1110, n);
    drain_frame(SCAN, tag);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    deck_card_cnt = 7'd0;
    oppo_card_cnt = 7'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (DIGIT !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_digit: got %b, want 1111", DIGIT);
    end
    n_cmp++;
    if (DISPLAY !== 7'h7F) begin
      n_err++;
      $display("FAIL reset_display: got %b, want 1111111", DISPLAY);
    end
    n_cmp++;
    if (dut.u_deck_bcd.state !== IDLE) begin
      n_err++;
      $display("FAIL reset_fsm: got %0d, want IDLE", dut.u_deck_bcd.state);
    end
    #1 rst = 1'b0;
    push_exp(0, 0);
    @(negedge clk);
    drain_frame(SCAN - 1, "reset_first");
    push_exp(0, 0);
    wait_to(4'b1110, n);
    drain_frame(SCAN, "reset_second");
  endtask

  task automatic test_latency();
    int n;
    int lat;
    wait_to(4'b1110, n);
    deck_card_cnt = 7'd42;
    oppo_card_cnt = 7'd7;
    push_exp(42, 7);
    wait_to(4'b0111, n);
    lat = 1;
    while (dut.u_deck_bcd.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL conv_latency: got %0d cycles, want 8", lat);
    end
    n_cmp++;
    if (dut.u_oppo_bcd.done !== 1'b1) begin
      n_err++;
      $display("FAIL conv_parallel: oppo done=%b, want 1", dut.u_oppo_bcd.done);
    end
    wait_to(4'b1110, n);
    drain_frame(SCAN, "deck42_oppo7");
  endtask

  task automatic test_midframe();
    int n;
    wait_to(4'b1110, n);
    deck_card_cnt = 7'd13;
    push_exp(42, 7);
    drain_frame(SCAN, "hold42");
    push_exp(13, 7);
    wait_to(4'b1110, n);
    drain_frame(SCAN, "show13");
  endtask

  task automatic test_dash();
    show_and_check(99, 100, "dash_99_100");
    show_and_check(127, 10, "dash_127_10");
    show_and_check(9, 0, "blank_9_0");
  endtask

  task automatic test_reset_abort();
    int n;
    wait_to(4'b1110, n);
    deck_card_cnt = 7'd55;
    oppo_card_cnt = 7'd3;
    wait_to(4'b0111, n);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut.u_deck_bcd.state !== SHIFT) begin
      n_err++;
      $display("FAIL abort_pre_state: got %0d, want SHIFT", dut.u_deck_bcd.state);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (DIGIT !== 4'b1111 || DISPLAY !== 7'h7F) begin
      n_err++;
      $display("FAIL abort_outputs: DIGIT=%b DISPLAY=%b, want 1111 1111111", DIGIT, DISPLAY);
    end
    n_cmp++;
    if (dut.u_deck_bcd.state !== IDLE || dut.u_oppo_bcd.state !== IDLE) begin
      n_err++;
      $display("FAIL abort_fsm: deck=%0d oppo=%0d, want IDLE", dut.u_deck_bcd.state,
               dut.u_oppo_bcd.state);
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    push_exp(0, 0);
    @(negedge clk);
    drain_frame(SCAN - 1, "post_abort");
    push_exp(55, 3);
    wait_to(4'b1110, n);
    drain_frame(SCAN, "recapture55");
  endtask

  task automatic test_sweep();
    int n;
    wait_to(4'b1110, n);
    deck_card_cnt = 7'd0;
    oppo_card_cnt = 7'd127;
    push_exp(0, 127);
    for (int v = 1; v <= 128; v++) begin
      wait_to(4'b1110, n);
      if (v < 128) begin
        deck_card_cnt = 7'(v);
        oppo_card_cnt = 7'(127 - v);
        push_exp(v, 127 - v);
      end
      drain_frame(SCAN, $sformatf("sweep%0d", v - 1));
    end
    n_cmp++;
    if (onehot_bad !== 0) begin
      n_err++;
      $display("FAIL digit_onehot: %0d cycles without exactly one low bit, want 0", onehot_bad);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_midframe();
    test_dash();
    test_reset_abort();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
